read_ptr_sync_level: RTL and testbench

Read-domain pointer synchronizer and occupancy monitor for the async FIFO. It brings the write-side gray pointer into the read clock domain through a flop chain and drives the synchronized pointer `rqr` into the read gray counter's empty comparison. It also converts the synchronized write pointer and the local read gray pointer to binary, and produces a registered fill level, an almost-empty flag and a sticky pointer-error flag for read-side consumers.

---
 rtl/read_ptr_sync_level_if.sv | 22 ++
 rtl/read_ptr_sync_level.sv | 72 +++++++
 tb/tb_read_ptr_sync_level.sv | 136 +++++++++++++
 3 files changed

// File: rtl/read_ptr_sync_level_if.sv
// Read-side pointer bundle for read_ptr_sync_level: raw pointers in, synchronized
// pointer and occupancy status out.
interface read_ptr_sync_level_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W:0] wgray;
    logic [ADDR_W:0] rgray;
    logic [ADDR_W:0] rqr;
    logic [ADDR_W:0] rlevel;
    logic            ralmost_empty;
    logic            ptr_err;

    modport master (
        output wgray, rgray,
        input  rqr, rlevel, ralmost_empty, ptr_err
    );

    modport slave (
        input  wgray, rgray,
        output rqr, rlevel, ralmost_empty, ptr_err
    );
endinterface

// File: rtl/read_ptr_sync_level.sv
// Write-pointer synchronizer into the read domain plus registered fill level,
// almost-empty and sticky pointer-error flags. Define SYNC3_EN for a 3-flop synchronizer.
module read_ptr_sync_level #(
    parameter int ADDR_W    = 4,
    parameter int AE_THRESH = 2
) (
    input logic                  clk,
    input logic                  rst,
    read_ptr_sync_level_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH  = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_THRESH);

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [ADDR_W:0] s1, s2;
    logic [ADDR_W:0] wbin_s, rbin, lvl_next;
    logic [ADDR_W:0] rlevel_q;
    logic            ae_q, err_q;

    // Only s1 ever sees the asynchronous wgray; no logic between stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.wgray;
            s2 <= s1;
        end
    end

`ifdef SYNC3_EN
    logic [ADDR_W:0] s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s3 <= '0;
        else     s3 <= s2;
    end

    assign bus.rqr = s3;
`else
    assign bus.rqr = s2;
`endif

    // Modulo subtraction absorbs the wrap of the pointer MSB.
    assign wbin_s   = gray2bin(bus.rqr);
    assign rbin     = gray2bin(bus.rgray);
    assign lvl_next = wbin_s - rbin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rlevel_q <= '0;
            ae_q     <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            rlevel_q <= lvl_next;
            ae_q     <= (lvl_next <= AE_LVL);
            if (lvl_next > DEPTH)
                err_q <= 1'b1;
        end
    end

    assign bus.rlevel        = rlevel_q;
    assign bus.ralmost_empty = ae_q;
    assign bus.ptr_err       = err_q;
endmodule

// File: tb/tb_read_ptr_sync_level.sv
// Directed bench for read_ptr_sync_level: reset, ramp, full/wrap, error, async reset.
module tb_read_ptr_sync_level;
`ifdef SYNC3_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int LV = LAT + 1;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    read_ptr_sync_level_if #(.ADDR_W(4)) bus ();

    read_ptr_sync_level #(.ADDR_W(4), .AE_THRESH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] gray(input int b);
        return 5'(b ^ (b >> 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with a non-zero write pointer waiting at the input
        rst       = 1'b1;
        bus.wgray = 5'b00110;
        bus.rgray = '0;
        tick();
        tick();
        chk("rst_rqr", 32'(bus.rqr), 0);
        chk("rst_rlevel", 32'(bus.rlevel), 0);
        chk("rst_ae", 32'(bus.ralmost_empty), 1);
        chk("rst_err", 32'(bus.ptr_err), 0);
        rst = 1'b0;
        repeat (LAT - 1) tick();
        chk("rel_rqr_early", 32'(bus.rqr), 0);
        tick();
        chk("rel_rqr", 32'(bus.rqr), 32'b00110);
        chk("rel_rlevel_early", 32'(bus.rlevel), 0);
        tick();
        chk("rel_rlevel", 32'(bus.rlevel), 4);
        chk("rel_ae", 32'(bus.ralmost_empty), 0);

        // incrementing write pointer from a clean state
        rst = 1'b1;
        bus.wgray = '0;
        #2;
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            int e, q;
            bus.wgray = gray((n - 1 > 5) ? 5 : n - 1);
            tick();
            e = n - LV;
            if (e < 0) e = 0;
            if (e > 5) e = 5;
            q = n - LAT;
            if (q < 0) q = 0;
            if (q > 5) q = 5;
            chk($sformatf("inc_rqr_%0d", n), 32'(bus.rqr), 32'(gray(q)));
            chk($sformatf("inc_lvl_%0d", n), 32'(bus.rlevel), 32'(e));
            chk($sformatf("inc_ae_%0d", n), 32'(bus.ralmost_empty), (e <= 2) ? 1 : 0);
        end

        // full: pointers differ only in MSB
        bus.wgray = gray(16);
        bus.rgray = '0;
        repeat (LV) tick();
        chk("full_lvl", 32'(bus.rlevel), 16);
        chk("full_err", 32'(bus.ptr_err), 0);
        chk("full_ae", 32'(bus.ralmost_empty), 0);

        // wrap: wbin 1, rbin 31 -> level 2
        bus.wgray = gray(1);
        repeat (LV) tick();
        chk("wrap_pre_lvl", 32'(bus.rlevel), 1);
        bus.rgray = gray(31);
        tick();
        chk("wrap_lvl", 32'(bus.rlevel), 2);
        chk("wrap_ae", 32'(bus.ralmost_empty), 1);
        chk("wrap_err", 32'(bus.ptr_err), 0);

        // error: level 20 exceeds depth, flag is sticky
        bus.rgray = '0;
        tick();
        chk("err_pre_lvl", 32'(bus.rlevel), 1);
        bus.wgray = gray(20);
        repeat (LV - 1) tick();
        chk("err_early", 32'(bus.ptr_err), 0);
        tick();
        chk("err_set", 32'(bus.ptr_err), 1);
        chk("err_lvl_raw", 32'(bus.rlevel), 20);
        bus.rgray = gray(20);
        repeat (3) tick();
        chk("err_eq_lvl", 32'(bus.rlevel), 0);
        chk("err_sticky", 32'(bus.ptr_err), 1);

        // mid-operation async reset with level 7
        bus.rgray = gray(13);
        tick();
        chk("mid_lvl", 32'(bus.rlevel), 7);
        chk("mid_err", 32'(bus.ptr_err), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_rqr", 32'(bus.rqr), 0);
        chk("mid_rst_lvl", 32'(bus.rlevel), 0);
        chk("mid_rst_ae", 32'(bus.ralmost_empty), 1);
        chk("mid_rst_err", 32'(bus.ptr_err), 0);
        #1;
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
